// File: rtl/mcpu_pkg.sv
// rtl/mcpu_pkg.sv - multicycle CPU control: state codes, opcode/function constants, ALU encodings
package mcpu_pkg;

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEM_ADDR = 5'd2,
    S_MEM_RD   = 5'd3,
    S_MEM_WB   = 5'd4,
    S_MEM_WR   = 5'd5,
    S_R_EXE    = 5'd6,
    S_R_WB     = 5'd7,
    S_I_EXE    = 5'd8,
    S_I_WB     = 5'd9,
    S_BEQ      = 5'd10,
    S_JUMP     = 5'd11,
    S_JAL      = 5'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FUN_ADD = 6'b100000;
  localparam logic [5:0] FUN_SUB = 6'b100010;
  localparam logic [5:0] FUN_AND = 6'b100100;
  localparam logic [5:0] FUN_OR  = 6'b100101;
  localparam logic [5:0] FUN_SLT = 6'b101010;
  localparam logic [5:0] FUN_NOR = 6'b100111;
  localparam logic [5:0] FUN_SRL = 6'b000010;
  localparam logic [5:0] FUN_XOR = 6'b100110;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Only signed add/sub style instructions drop their register write on overflow.
  function automatic logic ovf_checked(input logic [5:0] op, input logic [5:0] fun);
    return ((op == OP_RTYPE) && ((fun == FUN_ADD) || (fun == FUN_SUB))) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mcpu_if.sv
// rtl/mcpu_if.sv - controller <-> datapath/memory signal bundle
interface mcpu_if;
  logic [31:0] Inst;
  logic        zero;
  logic        overflow;
  logic        MIO_ready;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALU_operation;
  logic        Branch;
  logic        IorD;
  logic        IRWrite;
  logic [1:0]  MemtoReg;
  logic [1:0]  PCSource;
  logic        PCWrite;
  logic        PCWriteCond;
  logic [1:0]  RegDst;
  logic        RegWrite;
  logic        mem_w;
  logic        mem_err;
  logic [4:0]  state;

  modport master (
    input  Inst, zero, overflow, MIO_ready,
    output ALUSrcA, ALUSrcB, ALU_operation, Branch, IorD, IRWrite,
           MemtoReg, PCSource, PCWrite, PCWriteCond, RegDst, RegWrite,
           mem_w, mem_err, state
  );

  modport slave (
    output Inst, zero, overflow, MIO_ready,
    input  ALUSrcA, ALUSrcB, ALU_operation, Branch, IorD, IRWrite,
           MemtoReg, PCSource, PCWrite, PCWriteCond, RegDst, RegWrite,
           mem_w, mem_err, state
  );
endinterface

// File: rtl/mcpu_alu_dec.sv
// rtl/mcpu_alu_dec.sv - R-type function field to ALU operation decoder
module mcpu_alu_dec
  import mcpu_pkg::*;
(
  input  logic [5:0] fun,
  output logic [2:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = ALU_AND;
    valid  = 1'b1;
    case (fun)
      FUN_ADD: alu_op = ALU_ADD;
      FUN_SUB: alu_op = ALU_SUB;
      FUN_AND: alu_op = ALU_AND;
      FUN_OR:  alu_op = ALU_OR;
      FUN_SLT: alu_op = ALU_SLT;
      FUN_NOR: alu_op = ALU_NOR;
      FUN_SRL: alu_op = ALU_SRL;
      FUN_XOR: alu_op = ALU_XOR;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl.sv
// rtl/mcpu_ctrl.sv - multicycle CPU Moore control FSM; jal support under MCPU_JAL_EN
module mcpu_ctrl
  import mcpu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input logic   clk,
  input logic   reset_n,
  mcpu_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        cur, nxt;
  logic [CW-1:0] wait_cnt;
  logic          ovf_q;
  logic          mem_err_q;
  logic [5:0]    op, fun;
  logic [2:0]    r_alu;
  logic          r_ok;
  logic          waiting, timeout_hit;
  logic          unused_bits;

  assign op  = bus.Inst[31:26];
  assign fun = bus.Inst[5:0];
  assign unused_bits = ^{bus.zero, bus.Inst[25:6]};

  mcpu_alu_dec u_alu_dec (.fun(fun), .alu_op(r_alu), .valid(r_ok));

  assign waiting     = cur inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  assign timeout_hit = waiting && !bus.MIO_ready && (wait_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:    nxt = bus.MIO_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:       nxt = S_R_EXE;
          OP_LW, OP_SW:   nxt = S_MEM_ADDR;
          OP_BEQ:         nxt = S_BEQ;
          OP_ADDI, OP_SLTI: nxt = S_I_EXE;
          OP_J:           nxt = S_JUMP;
`ifdef MCPU_JAL_EN
          OP_JAL:         nxt = S_JAL;
`endif
          default:        nxt = S_FETCH;
        endcase
      end
      S_MEM_ADDR: nxt = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   nxt = bus.MIO_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   nxt = bus.MIO_ready ? S_FETCH : S_MEM_WR;
      S_R_EXE:    nxt = r_ok ? S_R_WB : S_FETCH;
      S_I_EXE:    nxt = S_I_WB;
      default:    nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur       <= S_FETCH;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      mem_err_q <= 1'b0;
      if (timeout_hit) begin
        cur       <= S_FETCH;
        wait_cnt  <= '0;
        mem_err_q <= 1'b1;
      end else begin
        cur      <= nxt;
        wait_cnt <= (waiting && !bus.MIO_ready) ? wait_cnt + CW'(1) : '0;
      end
      // Overflow is sampled in the execute cycle and consumed by the following write-back.
      if (cur == S_R_EXE || cur == S_I_EXE)
        ovf_q <= bus.overflow && ovf_checked(op, fun);
    end
  end

  logic       src_a, branch, iord, ir_write, pc_write, pc_write_cond, reg_write, mem_w;
  logic [1:0] src_b, mem_to_reg, pc_source, reg_dst;
  logic [2:0] alu_op;

  always_comb begin
    src_a = 1'b0; src_b = 2'b00; alu_op = ALU_AND; branch = 1'b0;
    iord = 1'b0; ir_write = 1'b0; mem_to_reg = 2'b00; pc_source = 2'b00;
    pc_write = 1'b0; pc_write_cond = 1'b0; reg_dst = 2'b00; reg_write = 1'b0;
    mem_w = 1'b0;
    case (cur)
      S_FETCH:    begin ir_write = 1'b1; src_b = 2'b01; alu_op = ALU_ADD; pc_write = 1'b1; end
      S_DECODE:   begin src_b = 2'b11; alu_op = ALU_ADD; end
      S_MEM_ADDR: begin src_a = 1'b1; src_b = 2'b10; alu_op = ALU_ADD; end
      S_MEM_RD:   iord = 1'b1;
      S_MEM_WB:   begin mem_to_reg = 2'b01; reg_write = 1'b1; end
      S_MEM_WR:   begin iord = 1'b1; mem_w = 1'b1; end
      S_R_EXE:    begin src_a = 1'b1; alu_op = r_alu; end
      S_R_WB:     begin reg_dst = 2'b01; reg_write = !ovf_q; end
      S_I_EXE:    begin src_a = 1'b1; src_b = 2'b10; alu_op = (op == OP_SLTI) ? ALU_SLT : ALU_ADD; end
      S_I_WB:     reg_write = !ovf_q;
      S_BEQ:      begin src_a = 1'b1; alu_op = ALU_SUB; pc_write_cond = 1'b1; branch = 1'b1; pc_source = 2'b01; end
      S_JUMP:     begin pc_source = 2'b10; pc_write = 1'b1; end
`ifdef MCPU_JAL_EN
      S_JAL:      begin reg_dst = 2'b10; mem_to_reg = 2'b10; reg_write = 1'b1; pc_source = 2'b10; pc_write = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Write strobes are gated by reset so nothing commits while reset_n is low.
  assign bus.PCWrite       = pc_write && reset_n;
  assign bus.IRWrite       = ir_write && reset_n;
  assign bus.RegWrite      = reg_write && reset_n;
  assign bus.mem_w         = mem_w && reset_n;
  assign bus.PCWriteCond   = pc_write_cond && reset_n;
  assign bus.ALUSrcA       = src_a;
  assign bus.ALUSrcB       = src_b;
  assign bus.ALU_operation = alu_op;
  assign bus.Branch        = branch;
  assign bus.IorD          = iord;
  assign bus.MemtoReg      = mem_to_reg;
  assign bus.PCSource      = pc_source;
  assign bus.RegDst        = reg_dst;
  assign bus.mem_err       = mem_err_q;
  assign bus.state         = cur;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb/tb_mcpu_ctrl.sv - directed self-checking bench for mcpu_ctrl
module tb_mcpu_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  mcpu_if bus ();

  mcpu_ctrl #(.TIMEOUT(15)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [31:0] I_LW   = {6'b100011, 20'h0, 6'b000000};
  localparam logic [31:0] I_SW   = {6'b101011, 20'h0, 6'b000000};
  localparam logic [31:0] I_BEQ  = {6'b000100, 20'h0, 6'b000000};
  localparam logic [31:0] I_ADD  = {6'b000000, 20'h0, 6'b100000};
  localparam logic [31:0] I_SUB  = {6'b000000, 20'h0, 6'b100010};
  localparam logic [31:0] I_BADF = {6'b000000, 20'h0, 6'b111111};
  localparam logic [31:0] I_ADDI = {6'b001000, 20'h0, 6'b000000};
  localparam logic [31:0] I_SLTI = {6'b001010, 20'h0, 6'b000000};
  localparam logic [31:0] I_J    = {6'b000010, 20'h0, 6'b000000};
  localparam logic [31:0] I_JAL  = {6'b000011, 20'h0, 6'b000000};
  localparam logic [31:0] I_ILL  = {6'b111111, 20'h0, 6'b000000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_no_strobe(input string tag);
    chk({tag, ".pcw"}, 32'(bus.PCWrite), 32'd0);
    chk({tag, ".irw"}, 32'(bus.IRWrite), 32'd0);
    chk({tag, ".rw"}, 32'(bus.RegWrite), 32'd0);
    chk({tag, ".memw"}, 32'(bus.mem_w), 32'd0);
    chk({tag, ".pcwc"}, 32'(bus.PCWriteCond), 32'd0);
  endtask

  // From FETCH: issue instruction with ready high, land in DECODE.
  task automatic fetch_decode(input logic [31:0] inst, input string tag);
    bus.Inst = inst; bus.MIO_ready = 1'b1; settle();
    chk({tag, ".fetch"}, 32'(bus.state), 32'd0);
    chk({tag, ".fetch_irw"}, 32'(bus.IRWrite), 32'd1);
    cyc(); bus.MIO_ready = 1'b0; settle();
    chk({tag, ".decode"}, 32'(bus.state), 32'd1);
    chk({tag, ".decode_srcb"}, 32'(bus.ALUSrcB), 32'd3);
    cyc();
  endtask

  initial begin
    bus.Inst = 32'h0; bus.zero = 1'b0; bus.overflow = 1'b0; bus.MIO_ready = 1'b0;
    cyc(); settle();
    chk("rst.state", 32'(bus.state), 32'd0);
    chk("rst.mem_err", 32'(bus.mem_err), 32'd0);
    chk_no_strobe("rst");
    reset_n = 1'b1;

    // lw with two stalled MEM_RD cycles
    fetch_decode(I_LW, "lw");
    settle();
    chk("lw.addr", 32'(bus.state), 32'd2);
    chk("lw.addr_srca", 32'(bus.ALUSrcA), 32'd1);
    chk("lw.addr_srcb", 32'(bus.ALUSrcB), 32'd2);
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.MIO_ready = (i == 2); settle();
      chk("lw.rd", 32'(bus.state), 32'd3);
      chk("lw.rd_iord", 32'(bus.IorD), 32'd1);
      chk("lw.rd_rw", 32'(bus.RegWrite), 32'd0);
    end
    cyc(); bus.MIO_ready = 1'b0; settle();
    chk("lw.wb", 32'(bus.state), 32'd4);
    chk("lw.wb_rw", 32'(bus.RegWrite), 32'd1);
    chk("lw.wb_m2r", 32'(bus.MemtoReg), 32'd1);
    chk("lw.wb_dst", 32'(bus.RegDst), 32'd0);
    cyc(); settle();
    chk("lw.back", 32'(bus.state), 32'd0);
    chk("lw.back_rw", 32'(bus.RegWrite), 32'd0);

    // beq with zero high then low: controller output identical
    for (int z = 1; z >= 0; z--) begin
      bus.zero = z[0];
      fetch_decode(I_BEQ, "beq");
      settle();
      chk("beq.state", 32'(bus.state), 32'd10);
      chk("beq.pcwc", 32'(bus.PCWriteCond), 32'd1);
      chk("beq.branch", 32'(bus.Branch), 32'd1);
      chk("beq.pcsrc", 32'(bus.PCSource), 32'd1);
      chk("beq.alu", 32'(bus.ALU_operation), 32'd6);
      cyc(); settle();
      chk("beq.back", 32'(bus.state), 32'd0);
    end

    // add with overflow set then clear
    for (int o = 1; o >= 0; o--) begin
      fetch_decode(I_ADD, "add");
      bus.overflow = o[0]; settle();
      chk("add.exe", 32'(bus.state), 32'd6);
      chk("add.alu", 32'(bus.ALU_operation), 32'd2);
      chk("add.srca", 32'(bus.ALUSrcA), 32'd1);
      chk("add.srcb", 32'(bus.ALUSrcB), 32'd0);
      cyc(); bus.overflow = 1'b0; settle();
      chk("add.wb", 32'(bus.state), 32'd7);
      chk("add.wb_rw", 32'(bus.RegWrite), 32'(1 - o));
      chk("add.wb_dst", 32'(bus.RegDst), 32'd1);
      cyc();
    end

    // sub ALU code; illegal function skips write-back
    fetch_decode(I_SUB, "sub");
    settle();
    chk("sub.alu", 32'(bus.ALU_operation), 32'd6);
    cyc(); cyc();
    fetch_decode(I_BADF, "badf");
    settle();
    chk("badf.exe", 32'(bus.state), 32'd6);
    cyc(); settle();
    chk("badf.back", 32'(bus.state), 32'd0);
    chk("badf.rw", 32'(bus.RegWrite), 32'd0);

    // addi overflow suppressed; slti with overflow still writes
    fetch_decode(I_ADDI, "addi");
    bus.overflow = 1'b1; settle();
    chk("addi.exe", 32'(bus.state), 32'd8);
    chk("addi.alu", 32'(bus.ALU_operation), 32'd2);
    cyc(); bus.overflow = 1'b0; settle();
    chk("addi.wb", 32'(bus.state), 32'd9);
    chk("addi.wb_rw", 32'(bus.RegWrite), 32'd0);
    cyc();
    fetch_decode(I_SLTI, "slti");
    bus.overflow = 1'b1; settle();
    chk("slti.alu", 32'(bus.ALU_operation), 32'd7);
    cyc(); bus.overflow = 1'b0; settle();
    chk("slti.wb_rw", 32'(bus.RegWrite), 32'd1);
    cyc();

    // jump
    fetch_decode(I_J, "j");
    settle();
    chk("j.state", 32'(bus.state), 32'd11);
    chk("j.pcsrc", 32'(bus.PCSource), 32'd2);
    chk("j.pcw", 32'(bus.PCWrite), 32'd1);
    cyc();

    // illegal opcode: DECODE then FETCH, no strobes
    bus.Inst = I_ILL; bus.MIO_ready = 1'b1; settle();
    cyc(); bus.MIO_ready = 1'b0; settle();
    chk("ill.decode", 32'(bus.state), 32'd1);
    chk_no_strobe("ill");
    cyc(); settle();
    chk("ill.back", 32'(bus.state), 32'd0);

    // jal
    bus.Inst = I_JAL; bus.MIO_ready = 1'b1; settle();
    cyc(); bus.MIO_ready = 1'b0; settle();
    chk("jal.decode", 32'(bus.state), 32'd1);
    cyc(); settle();
`ifdef MCPU_JAL_EN
    chk("jal.state", 32'(bus.state), 32'd12);
    chk("jal.dst", 32'(bus.RegDst), 32'd2);
    chk("jal.m2r", 32'(bus.MemtoReg), 32'd2);
    chk("jal.rw", 32'(bus.RegWrite), 32'd1);
    chk("jal.pcsrc", 32'(bus.PCSource), 32'd2);
    chk("jal.pcw", 32'(bus.PCWrite), 32'd1);
    cyc(); settle();
`endif
    chk("jal.fetch", 32'(bus.state), 32'd0);
    chk("jal.nodst", 32'(bus.RegDst), 32'd0);

    // sw timeout: 15 stalled cycles in MEM_WR
    fetch_decode(I_SW, "sw");
    cyc();
    for (int i = 0; i < 15; i++) begin
      settle();
      chk("sw.wr", 32'(bus.state), 32'd5);
      chk("sw.memw", 32'(bus.mem_w), 32'd1);
      chk("sw.noerr", 32'(bus.mem_err), 32'd0);
      cyc();
    end
    settle();
    chk("sw.to_state", 32'(bus.state), 32'd0);
    chk("sw.to_err", 32'(bus.mem_err), 32'd1);
    chk("sw.to_memw", 32'(bus.mem_w), 32'd0);
    cyc(); settle();
    chk("sw.err_pulse", 32'(bus.mem_err), 32'd0);
    chk("sw.after_memw", 32'(bus.mem_w), 32'd0);
    chk("sw.after_state", 32'(bus.state), 32'd0);

    // reset dropped in MEM_WR
    fetch_decode(I_SW, "swr");
    cyc(); settle();
    chk("swr.wr", 32'(bus.state), 32'd5);
    chk("swr.memw", 32'(bus.mem_w), 32'd1);
    reset_n = 1'b0; settle();
    chk("swr.rst_memw", 32'(bus.mem_w), 32'd0);
    chk("swr.rst_state", 32'(bus.state), 32'd0);
    chk_no_strobe("swr");
    cyc();
    reset_n = 1'b1; bus.MIO_ready = 1'b1; settle();
    chk("swr.rel_state", 32'(bus.state), 32'd0);
    chk("swr.rel_irw", 32'(bus.IRWrite), 32'd1);
    cyc(); settle();
    chk("swr.rel_decode", 32'(bus.state), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
